// File: rtl/program_loader.sv
// program_loader
//
// Front-end stage that owns the SPM write port until a program image has
// been loaded. It takes a byte stream (length, payload, checksum), writes
// the payload into memory from address 0 upward, and on a good checksum
// hands the memory port to the CPU and releases it via cpu_run_o. A bad
// checksum parks the loader in an error state with the CPU locked out.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             begin a load (honoured only in IDLE, RUN, ERR)
//   in_valid_i/in_data_i/in_ready_o   byte stream input
//   cpu_address_i/cpu_Bus_1_i/cpu_write_i   CPU-side memory request
//   mem_address_o/mem_Bus_1_o/mem_write_o   memory unit write port
//   cpu_run_o           program valid, CPU reset release
//   load_err_o          checksum mismatch on the last load
//   busy_o              load in progress (LEN, DATA, CSUM)
//   loaded_count_o      payload bytes written in the current/last load
//   state_o             current FSM state, for observation
//
// Handshake: a byte is transferred on a rising edge where in_valid_i and
// in_ready_o are both high. in_valid_i may be dropped at any time; the
// loader simply holds its state. in_ready_o depends only on the state.
module program_loader #(
    parameter int word_size = 8,
    parameter int depth     = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 in_valid_i,
    input  logic [word_size-1:0] in_data_i,
    output logic                 in_ready_o,
    input  logic [word_size-1:0] cpu_address_i,
    input  logic [word_size-1:0] cpu_Bus_1_i,
    input  logic                 cpu_write_i,
    output logic [word_size-1:0] mem_address_o,
    output logic [word_size-1:0] mem_Bus_1_o,
    output logic                 mem_write_o,
    output logic                 cpu_run_o,
    output logic                 load_err_o,
    output logic                 busy_o,
    output logic [word_size:0]   loaded_count_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_RUN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [word_size-1:0] PTR_ONE = 1;
    localparam logic [word_size:0]   CNT_ONE = 1;
    // A length byte of 0 encodes a full memory image.
    localparam logic [word_size:0]   FULL_LEN = depth;

    state_t               state_q, state_d;
    logic [word_size-1:0] ptr_q, ptr_d;
    logic [word_size-1:0] sum_q, sum_d;
    logic [word_size:0]   cnt_q, cnt_d;
    logic [word_size:0]   rem_q, rem_d;
    logic [word_size-1:0] csum_total;
    logic                 loading;
    logic                 xfer;

    assign loading    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer       = in_valid_i && loading;
    assign csum_total = sum_q + in_data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start_i) begin
                    state_d = S_LEN;
                    ptr_d   = '0;
                    sum_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    rem_d   = (in_data_i == '0) ? FULL_LEN : {1'b0, in_data_i};
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // ptr wraps naturally because depth == 2**word_size.
                    ptr_d = ptr_q + PTR_ONE;
                    sum_d = sum_q + in_data_i;
                    cnt_d = cnt_q + CNT_ONE;
                    rem_d = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (csum_total == '0) ? S_RUN : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port mux. The CPU only reaches memory in RUN; during DATA the
    // stream byte goes straight to memory on its transfer edge.
    always_comb begin
        mem_address_o = ptr_q;
        mem_Bus_1_o   = '0;
        mem_write_o   = 1'b0;
        if (state_q == S_RUN) begin
            mem_address_o = cpu_address_i;
            mem_Bus_1_o   = cpu_Bus_1_i;
            mem_write_o   = cpu_write_i;
        end else if (state_q == S_DATA) begin
            mem_Bus_1_o = in_data_i;
            mem_write_o = in_valid_i;
        end
    end

    assign in_ready_o     = loading;
    assign busy_o         = loading;
    assign cpu_run_o      = (state_q == S_RUN);
    assign load_err_o     = (state_q == S_ERR);
    assign loaded_count_o = cnt_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] cpu_address;
  logic [7:0] cpu_bus_1;
  logic       cpu_write;
  logic [7:0] mem_address;
  logic [7:0] mem_bus_1;
  logic       mem_write;
  logic       cpu_run;
  logic       load_err;
  logic       busy;
  logic [8:0] loaded_count;
  logic [2:0] state_dbg;

  int n_total = 0;
  int n_pass  = 0;

  program_loader #(.word_size(8), .depth(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_ready_o     (in_ready),
    .cpu_address_i  (cpu_address),
    .cpu_Bus_1_i    (cpu_bus_1),
    .cpu_write_i    (cpu_write),
    .mem_address_o  (mem_address),
    .mem_Bus_1_o    (mem_bus_1),
    .mem_write_o    (mem_write),
    .cpu_run_o      (cpu_run),
    .load_err_o     (load_err),
    .busy_o         (busy),
    .loaded_count_o (loaded_count),
    .state_o        (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SPM stand-in fed by the DUT write port ----------------
  logic [7:0] spm [256];
  always @(posedge clk) begin
    if (mem_write) spm[mem_address] <= mem_bus_1;
  end

  // ---------------- behavioural model ----------------
  // Phase names: 0 idle, 1 expect length, 2 expect payload, 3 expect
  // checksum, 4 program running, 5 checksum error.
  int m_ph;
  int m_ptr;
  int m_sum;
  int m_cnt;
  int m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_ptr = 0; m_sum = 0; m_cnt = 0; m_rem = 0;
    end else if (start && (m_ph == 0 || m_ph == 4 || m_ph == 5)) begin
      m_ph = 1; m_ptr = 0; m_sum = 0; m_cnt = 0;
    end else if (in_valid && m_ph >= 1 && m_ph <= 3) begin
      if (m_ph == 1) begin
        m_rem = (in_data == 0) ? 256 : int'(in_data);
        m_ph  = 2;
      end else if (m_ph == 2) begin
        m_ptr = (m_ptr + 1) % 256;
        m_sum = (m_sum + int'(in_data)) % 256;
        m_cnt = m_cnt + 1;
        m_rem = m_rem - 1;
        if (m_rem == 0) m_ph = 3;
      end else begin
        m_ph = (((m_sum + int'(in_data)) % 256) == 0) ? 4 : 5;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic ld;
      int e_addr, e_bus, e_wr;
      ld = (m_ph >= 1 && m_ph <= 3);
      if (m_ph == 4) begin
        e_addr = cpu_address; e_bus = cpu_bus_1; e_wr = cpu_write;
      end else if (m_ph == 2) begin
        e_addr = m_ptr; e_bus = in_data; e_wr = in_valid;
      end else begin
        e_addr = m_ptr; e_bus = 0; e_wr = 0;
      end
      chk("cyc_in_ready", in_ready, ld);
      chk("cyc_busy", busy, ld);
      chk("cyc_cpu_run", cpu_run, (m_ph == 4));
      chk("cyc_load_err", load_err, (m_ph == 5));
      chk("cyc_loaded_count", loaded_count, m_cnt);
      chk("cyc_mem_write", mem_write, e_wr);
      chk("cyc_mem_address", mem_address, e_addr);
      chk("cyc_mem_bus", mem_bus_1, e_bus);
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  logic [7:0] pl [256];

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    idle_cycles((maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic load(input logic [7:0] len, input int n, input logic [7:0] cs,
                      input int maxgap, input int start_after);
    pulse_start();
    send(len, maxgap);
    for (int i = 0; i < n; i++) begin
      send(pl[i], maxgap);
      if (i == start_after) pulse_start();
    end
    send(cs, maxgap);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cpu_address = 8'h00; cpu_bus_1 = 8'h00; cpu_write = 1'b0;
    for (int i = 0; i < 256; i++) spm[i] = 8'hEE;
    idle_cycles(3);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_loaded_count", loaded_count, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Good 3-byte load.
    pl[0] = 8'h12; pl[1] = 8'h34; pl[2] = 8'h56;
    load(8'd3, 3, 8'h64, 0, -1);
    chk("t1_cpu_run", cpu_run, 1);
    chk("t1_load_err", load_err, 0);
    chk("t1_count", loaded_count, 3);
    chk("t1_mem0", spm[0], 8'h12);
    chk("t1_mem1", spm[1], 8'h34);
    chk("t1_mem2", spm[2], 8'h56);

    // CPU write lands on the same cycle in RUN.
    cpu_write = 1'b1; cpu_address = 8'h05; cpu_bus_1 = 8'hAA;
    #1;
    chk("t6_mem_write", mem_write, 1);
    chk("t6_mem_address", mem_address, 8'h05);
    @(posedge clk); #1;
    cpu_write = 1'b0;
    chk("t6_mem5", spm[5], 8'hAA);

    // Start in RUN drops cpu_run the next cycle; bad checksum.
    pulse_start();
    chk("t2_run_dropped", cpu_run, 0);
    chk("t2_rearmed", in_ready, 1);
    send(8'd3, 0);
    send(pl[0], 0); send(pl[1], 0); send(pl[2], 0);
    send(8'h65, 0);
    chk("t2_load_err", load_err, 1);
    chk("t2_cpu_run", cpu_run, 0);
    chk("t2_mem2", spm[2], 8'h56);
    cpu_write = 1'b1; cpu_address = 8'h00; cpu_bus_1 = 8'h77;
    #1;
    chk("t2_cpu_blocked", mem_write, 0);
    @(posedge clk); #1;
    cpu_write = 1'b0;
    chk("t2_mem0_kept", spm[0], 8'h12);

    // Full 256-byte image.
    for (int i = 0; i < 256; i++) pl[i] = 8'(i);
    load(8'd0, 256, 8'h80, 0, -1);
    chk("t3_count", loaded_count, 256);
    chk("t3_cpu_run", cpu_run, 1);
    chk("t3_mem00", spm[0], 8'h00);
    chk("t3_mem7f", spm[127], 8'h7F);
    chk("t3_memff", spm[255], 8'hFF);

    // Gapped stream with a stray start in DATA.
    for (int i = 0; i < 6; i++) begin
      pl[i] = 8'(i + 1);
      spm[i] = 8'hEE;
    end
    load(8'd6, 6, 8'hEB, 3, 1);
    chk("t4_cpu_run", cpu_run, 1);
    chk("t4_count", loaded_count, 6);
    for (int i = 0; i < 6; i++) chk("t4_mem", spm[i], 8'(i + 1));
    chk("t4_mem6", spm[6], 8'h06);

    // Reset mid-load, then a full good load.
    for (int i = 0; i < 10; i++) pl[i] = 8'(8'h10 + i);
    pulse_start();
    send(8'd10, 0);
    for (int i = 0; i < 4; i++) send(pl[i], 0);
    in_valid = 1'b1; in_data = pl[4];
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_mem_write", mem_write, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_count", loaded_count, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle_cycles(1);
    load(8'd10, 10, 8'h33, 0, -1);
    chk("t5_cpu_run", cpu_run, 1);
    chk("t5_count", loaded_count, 10);
    chk("t5_mem9", spm[9], 8'h19);
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Front-end stage that sits directly upstream of the SPM memory unit and owns its write port until a program image has been loaded. It accepts a byte stream over a valid/ready handshake and writes the payload into memory from address 0 upward. The stream is a length byte, the payload bytes, then a checksum byte. On a good checksum it hands the memory port to the processing/control units and raises `cpu_run`; on a bad checksum it raises `load_err` and keeps the CPU locked out.

## Interface
- `word_size`, 8, data and address width; the address is `word_size` bits wide.
- `depth`, 256, memory depth; must equal 2**`word_size`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: pulse that begins a load; honoured only in IDLE, RUN and ERR.
- `in_valid` in 1: a stream byte is present.
- `in_data` in `word_size`: stream byte.
- `in_ready` out 1: the loader accepts a byte this cycle.
- `cpu_address` in `word_size`: address requested by the CPU.
- `cpu_Bus_1` in `word_size`: write data from the CPU.
- `cpu_write` in 1: CPU write strobe.
- `mem_address` out `word_size`: address to the memory unit.
- `mem_Bus_1` out `word_size`: write data to the memory unit.
- `mem_write` out 1: write strobe to the memory unit.
- `cpu_run` out 1: high means the program is valid and the CPU may execute; it is the CPU reset release.
- `load_err` out 1: checksum mismatch on the last load.
- `busy` out 1: a load is in progress (LEN, DATA or CSUM).
- `loaded_count` out `word_size`+1: payload bytes written in the current or last load.

## Operation
- States: IDLE, LEN, DATA, CSUM, RUN, ERR.
- A transfer (xfer) occurs in a cycle where `in_valid` && `in_ready`.
- IDLE, RUN, ERR: `start` moves to LEN and clears `ptr`, `sum`, `loaded_count`, `cpu_run` and `load_err`.
- LEN, DATA, CSUM: `start` is ignored.
- LEN, on xfer: `remaining` = `in_data`; a value of 0 means `depth` (256). Next state is DATA.
- DATA, on xfer, the loader writes `in_data` to memory at `ptr`, then:
  - `ptr` increments and wraps modulo `depth`.
  - `sum` += `in_data` modulo 2**`word_size`.
  - `loaded_count` increments.
  - `remaining` decrements; on the last byte the next state is CSUM.
- CSUM, on xfer: if (`sum` + `in_data`) modulo 256 == 0, go to RUN with `cpu_run`=1. Otherwise go to ERR with `load_err`=1.
- `in_ready` = 1 exactly in LEN, DATA and CSUM; otherwise 0. `busy` equals the same condition.
- Memory port mux, all combinational:
  - RUN: `mem_address`=`cpu_address`, `mem_Bus_1`=`cpu_Bus_1`, `mem_write`=`cpu_write`.
  - DATA: `mem_address`=`ptr`, `mem_Bus_1`=`in_data`, `mem_write`=`in_valid` (equal to xfer).
  - All other states: `mem_address`=`ptr`, `mem_Bus_1`=0, `mem_write`=0. `cpu_write` is blocked.
- Memory contents are not cleared by this block. A failed or aborted load leaves the bytes already written in place.

## Timing
- Reset values: state IDLE; `in_ready`, `busy`, `cpu_run`, `load_err` and `mem_write` 0; `loaded_count`, `ptr` and `sum` 0.
- `start` sampled high in an allowed state puts `in_ready` high the next cycle.
- A DATA byte reaches memory on the same rising edge as its xfer, so there is zero added latency.
- The CSUM xfer edge sets `cpu_run` or `load_err` visible the next cycle. The first CPU write can land one cycle after the CSUM xfer.
- `in_valid` low stalls any state indefinitely with no state change.
- Back-to-back xfers every cycle are supported. A minimum load of N payload bytes takes N+2 xfer cycles after `start`.
- `rst_n` asserted mid-load forces IDLE immediately, asynchronously. `mem_write` drops to 0 without waiting for a clock.
- Length 0 (256 bytes): `ptr` wraps from 255 to 0 after the last write; `loaded_count` ends at 256.
- `start` asserted in RUN drops `cpu_run` the next cycle and re-arms the loader.

## Test plan
- Length 3, data 0x12 0x34 0x56, checksum 0x64 (sum 0x9C) -> memory[0..2] = 12/34/56; `cpu_run`=1, `load_err`=0, `loaded_count`=3.
- Same stream with checksum 0x65 -> `load_err`=1, `cpu_run`=0; memory[0..2] is still written; a `cpu_write` pulse produces no `mem_write`.
- Length 0, data 0x00..0xFF, checksum 0x80 (sum 0x7F80 mod 256 = 0x80) -> 256 writes, `loaded_count`=256, `cpu_run`=1.
- Random `in_valid` gaps plus a `start` pulse mid-DATA -> the stall holds state, the `start` is ignored, and the final memory image is identical to the gap-free run.
- Load 10 bytes, drop `rst_n` after the 4th data xfer -> same-cycle return to IDLE, `in_ready`=0, `mem_write`=0; a following `start` and full load succeeds.
- After a good load, `cpu_write`=1 with `cpu_address`=0x05 and `cpu_Bus_1`=0xAA -> `mem_write`=1 and `mem_address`=0x05 are seen on the same cycle.
